class_vec_seq_ctrl: RTL and testbench
=====================================

Name: class_vec_seq_ctrl

Overview:
- Sequencer that sweeps the class hypervector generator (frame_id / frame_index addressed, combinational ROM) and streams every chunk to the similarity/distance datapath.
- Handles the ready/valid stream with full backpressure at 1 beat/cycle throughput, and flags last-frame and last-beat boundaries.
- Sits between the inference controller (start/abort/done) and the class-vector consumer.

Parameters:
- DI_PARALLEL_W_BITS, 64: chunk width; matches the generator output.
- NUM_CLASSES, 8: classes swept; legal range 1..2**CLASS_ID_W.
- NUM_FRAMES, 3: frames per class; legal range 1..2**FRAME_IDX_W.
- CLASS_ID_W, 3: frame_id width.
- FRAME_IDX_W, 2: frame_index width.

Ports:
- clk, input, 1: single clock; rising edge.
- rst, input, 1: synchronous, active-high reset.
- start_i, input, 1: sweep request; sampled only in IDLE.
- abort_i, input, 1: cancels the sweep in progress.
- busy_o, output, 1: high while not IDLE.
- done_o, output, 1: one-cycle pulse after the last beat handshakes.
- frame_id_o, output, CLASS_ID_W: generator class address.
- frame_index_o, output, FRAME_IDX_W: generator frame address.
- class_vec_i, input, DI_PARALLEL_W_BITS: generator data.
- m_valid_o, output, 1: stream valid.
- m_ready_i, input, 1: stream ready.
- m_data_o, output, DI_PARALLEL_W_BITS: registered chunk.
- m_class_id_o, output, CLASS_ID_W: class of the current beat.
- m_frame_idx_o, output, FRAME_IDX_W: frame of the current beat.
- m_last_frame_o, output, 1: high when the beat is the last frame of its class.
- m_last_o, output, 1: high when the beat is the final beat of the sweep.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous, active-high, on clk/rst.
- Reset values:
  - state = IDLE; address counters = 0.
  - m_valid_o, busy_o, done_o, m_last_o, m_last_frame_o = 0.
  - m_data_o, m_class_id_o, m_frame_idx_o = 0.
- Address outputs: frame_id_o and frame_index_o are driven from the counters. class_vec_i is treated as combinational, valid in the same cycle.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start_i=1 → clear counters, go to RUN.
  - start_i is ignored in RUN and DRAIN.
- Output register load condition: load = (!m_valid_o | m_ready_i), evaluated in RUN.
- RUN:
  - On load: capture class_vec_i, the counter values and the last flags into the output register; set m_valid_o=1.
  - Advance order: frame_index increments first; it wraps at NUM_FRAMES-1 → 0 and frame_id increments.
  - On the load of (NUM_CLASSES-1, NUM_FRAMES-1), go to DRAIN.
- DRAIN:
  - On m_valid_o & m_ready_i: m_valid_o=0, done_o=1 for one cycle, go to IDLE.
- Stall rule: while m_valid_o=1 and m_ready_i=0, all m_* outputs and the counters hold stable.
- Latency (start_i sampled at edge E0):
  - Beat k is first presented after edge E(k+1).
  - With m_ready_i held at 1, 1 beat/cycle; done_o is high after edge E(N+1), where N = NUM_CLASSES*NUM_FRAMES.
- busy_o = (state != IDLE), registered. It falls in the same cycle that done_o rises.
- Back-to-back sweeps: start_i during the done_o cycle is accepted (state is IDLE).
- abort_i (any non-IDLE state):
  - Next cycle: IDLE, m_valid_o=0, no done_o, counters cleared.
  - abort_i has priority over a simultaneous handshake.
  - abort_i in IDLE has no effect and takes priority over start_i.
- rst mid-sweep behaves exactly as the reset values; no done_o.
- Degenerate sizes: NUM_CLASSES=1 and/or NUM_FRAMES=1 are legal. With NUM_FRAMES=1, m_last_frame_o=1 on every beat.

Optional Feature:
- Macro: CLASS_SEQ_FRAME_MAJOR_EN.
- Defined: frame-major order. frame_id increments first and wraps at NUM_CLASSES-1; frame_index increments on that wrap. This feeds the class-parallel lanes frame by frame.
  - m_last_frame_o = (frame_index == NUM_FRAMES-1), unchanged.
  - Termination address is unchanged: (NUM_CLASSES-1, NUM_FRAMES-1).
- Undefined: class-major order as specified above.

Test Plan:
- Free-run: rst, start_i pulse, m_ready_i=1 → 24 beats on consecutive cycles.
  - Order (0,0),(0,1),(0,2),(1,0)…(7,2).
  - m_data_o equals the generator word per address.
  - m_last_frame_o on frame 2; m_last_o only on beat 23.
  - done_o at E25, one cycle.
- Backpressure: m_ready_i random 50%, then low for 5 cycles at beat 10 → m_* outputs stable while stalled; no beats lost or duplicated; 24 handshakes total.
- Abort: abort_i at beat 7 (stalled and unstalled variants) → m_valid_o=0 next cycle, busy_o=0, no done_o; a following start_i restarts at (0,0).
- Start in the done_o cycle → second sweep begins. start_i pulses during RUN → ignored; beat count stays 24.
- Sync reset asserted mid-sweep at beat 12 → all outputs at reset values after the edge; no done_o.
- CLASS_SEQ_FRAME_MAJOR_EN build → order (0,0),(1,0)…(7,0),(0,1)…(7,2); m_last_o on (7,2); done_o at E25.

Source files
------------

// File: rtl/class_vec_seq_ctrl.sv
// Class hypervector sequencer: sweeps the generator ROM by (frame_id, frame_index) and
// streams each chunk over ready/valid. Define CLASS_SEQ_FRAME_MAJOR_EN for frame-major order.
module class_vec_seq_ctrl #(
    parameter int DI_PARALLEL_W_BITS = 64,
    parameter int NUM_CLASSES        = 8,
    parameter int NUM_FRAMES         = 3,
    parameter int CLASS_ID_W         = 3,
    parameter int FRAME_IDX_W        = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic                          abort_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [CLASS_ID_W-1:0]         frame_id_o,
    output logic [FRAME_IDX_W-1:0]        frame_index_o,
    input  logic [DI_PARALLEL_W_BITS-1:0] class_vec_i,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic [DI_PARALLEL_W_BITS-1:0] m_data_o,
    output logic [CLASS_ID_W-1:0]         m_class_id_o,
    output logic [FRAME_IDX_W-1:0]        m_frame_idx_o,
    output logic                          m_last_frame_o,
    output logic                          m_last_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [CLASS_ID_W-1:0]  LP_LAST_CLS = CLASS_ID_W'(NUM_CLASSES - 1);
    localparam logic [FRAME_IDX_W-1:0] LP_LAST_FRM = FRAME_IDX_W'(NUM_FRAMES - 1);

    state_t                          r_state;
    logic [CLASS_ID_W-1:0]           r_cls;
    logic [FRAME_IDX_W-1:0]          r_frm;
    logic                            r_busy;
    logic                            r_done;
    logic                            r_valid;
    logic [DI_PARALLEL_W_BITS-1:0]   r_data;
    logic [CLASS_ID_W-1:0]           r_beat_cls;
    logic [FRAME_IDX_W-1:0]          r_beat_frm;
    logic                            r_last_frame;
    logic                            r_last;

    logic                            w_at_last_cls;
    logic                            w_at_last_frm;
    logic                            w_at_end;
    logic                            w_load;
    logic                            w_hs;
    logic [CLASS_ID_W-1:0]           w_cls_nxt;
    logic [FRAME_IDX_W-1:0]          w_frm_nxt;

    assign w_at_last_cls = (r_cls == LP_LAST_CLS);
    assign w_at_last_frm = (r_frm == LP_LAST_FRM);
    assign w_at_end      = w_at_last_cls & w_at_last_frm;
    assign w_load        = ~r_valid | m_ready_i;
    assign w_hs          = r_valid & m_ready_i;

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        w_cls_nxt = r_cls;
        w_frm_nxt = r_frm;
`ifdef CLASS_SEQ_FRAME_MAJOR_EN
        if (w_at_last_cls) begin
            w_cls_nxt = '0;
            w_frm_nxt = r_frm + 1'b1;
        end else begin
            w_cls_nxt = r_cls + 1'b1;
        end
`else
        if (w_at_last_frm) begin
            w_frm_nxt = '0;
            w_cls_nxt = r_cls + 1'b1;
        end else begin
            w_frm_nxt = r_frm + 1'b1;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cls        <= '0;
            r_frm        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_beat_cls   <= '0;
            r_beat_frm   <= '0;
            r_last_frame <= 1'b0;
            r_last       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Abort wins over any handshake in flight and never produces done.
            if (r_state != ST_IDLE && abort_i) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_valid <= 1'b0;
                r_cls   <= '0;
                r_frm   <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start_i && !abort_i) begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                            r_cls   <= '0;
                            r_frm   <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (w_load) begin
                            r_data       <= class_vec_i;
                            r_beat_cls   <= r_cls;
                            r_beat_frm   <= r_frm;
                            r_last_frame <= w_at_last_frm;
                            r_last       <= w_at_end;
                            r_valid      <= 1'b1;
                            if (w_at_end) begin
                                r_state <= ST_DRAIN;
                                r_cls   <= '0;
                                r_frm   <= '0;
                            end else begin
                                r_cls <= w_cls_nxt;
                                r_frm <= w_frm_nxt;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (w_hs) begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy_o         = r_busy;
    assign done_o         = r_done;
    assign frame_id_o     = r_cls;
    assign frame_index_o  = r_frm;
    assign m_valid_o      = r_valid;
    assign m_data_o       = r_data;
    assign m_class_id_o   = r_beat_cls;
    assign m_frame_idx_o  = r_beat_frm;
    assign m_last_frame_o = r_last_frame;
    assign m_last_o       = r_last;

endmodule

// File: tb/tb_class_vec_seq_ctrl.sv
// Self-checking bench for class_vec_seq_ctrl: random backpressure against an address-order
// model built from nested loops, plus abort, reset, back-to-back and ignored-start scenarios.
module tb_class_vec_seq_ctrl;

    localparam int W  = 64;
    localparam int NC = 8;
    localparam int NF = 3;
    localparam int CW = 3;
    localparam int FW = 2;
    localparam int N  = NC * NF;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic          abort_i;
    logic          busy_o;
    logic          done_o;
    logic [CW-1:0] frame_id_o;
    logic [FW-1:0] frame_index_o;
    logic [W-1:0]  class_vec_i;
    logic          m_valid_o;
    logic          m_ready_i;
    logic [W-1:0]  m_data_o;
    logic [CW-1:0] m_class_id_o;
    logic [FW-1:0] m_frame_idx_o;
    logic          m_last_frame_o;
    logic          m_last_o;

    int errors = 0;
    int checks = 0;
    int exp_c[$];
    int exp_f[$];

    always #5 clk = ~clk;

    // Generator ROM model: a distinct word per (class, frame).
    function automatic logic [63:0] gen_word(input int c, input int f);
        logic [31:0] hi;
        logic [31:0] lo;
        hi = 32'hC1A5_0000 | 32'(c << 8) | 32'(f);
        lo = 32'(c * 1000 + f * 7 + 1) ^ 32'h5A5A_5A5A;
        return {hi, lo};
    endfunction

    assign class_vec_i = gen_word(int'(frame_id_o), int'(frame_index_o));

    class_vec_seq_ctrl #(
        .DI_PARALLEL_W_BITS(W),
        .NUM_CLASSES       (NC),
        .NUM_FRAMES        (NF),
        .CLASS_ID_W        (CW),
        .FRAME_IDX_W       (FW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .frame_id_o    (frame_id_o),
        .frame_index_o (frame_index_o),
        .class_vec_i   (class_vec_i),
        .m_valid_o     (m_valid_o),
        .m_ready_i     (m_ready_i),
        .m_data_o      (m_data_o),
        .m_class_id_o  (m_class_id_o),
        .m_frame_idx_o (m_frame_idx_o),
        .m_last_frame_o(m_last_frame_o),
        .m_last_o      (m_last_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_valid"},  64'(m_valid_o), 64'(0));
        check({nm, "_busy"},   64'(busy_o), 64'(0));
        check({nm, "_done"},   64'(done_o), 64'(0));
        check({nm, "_last"},   64'(m_last_o), 64'(0));
        check({nm, "_lastfr"}, 64'(m_last_frame_o), 64'(0));
        check({nm, "_data"},   m_data_o, 64'(0));
        check({nm, "_mcls"},   64'(m_class_id_o), 64'(0));
        check({nm, "_mfrm"},   64'(m_frame_idx_o), 64'(0));
        check({nm, "_fid"},    64'(frame_id_o), 64'(0));
        check({nm, "_fidx"},   64'(frame_index_o), 64'(0));
    endtask

    // Called at a negedge; pulses start_i across one rising edge.
    task automatic do_start(input string nm);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check({nm, "_start_busy"},  64'(busy_o), 64'(1));
        check({nm, "_start_valid"}, 64'(m_valid_o), 64'(0));
    endtask

    // Runs one sweep from the negedge after start; ends at the done cycle, or after an
    // injected abort/reset has been checked.
    task automatic stream(input string nm, input int pct, input int low_beat,
                          input int abort_beat, input bit abort_stall,
                          input int rst_beat, input bit start_noise);
        int idx = 0;
        int cyc = 0;
        int low_cnt = 0;
        bit prev_stall = 1'b0;
        bit finished = 1'b0;
        bit pend_abort = 1'b0;
        bit pend_rst = 1'b0;
        m_ready_i = 1'b1;
        while (!finished && cyc < 500) begin
            @(negedge clk);
            cyc++;
            start_i = 1'b0;
            abort_i = 1'b0;
            if (pend_abort) begin
                check({nm, "_abort_valid"}, 64'(m_valid_o), 64'(0));
                check({nm, "_abort_busy"},  64'(busy_o), 64'(0));
                check({nm, "_abort_done"},  64'(done_o), 64'(0));
                check({nm, "_abort_fid"},   64'(frame_id_o), 64'(0));
                check({nm, "_abort_fidx"},  64'(frame_index_o), 64'(0));
                @(negedge clk);
                check({nm, "_abort_nodone"}, 64'(done_o), 64'(0));
                finished = 1'b1;
            end else if (pend_rst) begin
                rst = 1'b0;
                check_all_zero({nm, "_rst"});
                @(negedge clk);
                check({nm, "_rst_nodone"}, 64'(done_o), 64'(0));
                finished = 1'b1;
            end else if (done_o) begin
                check({nm, "_done_valid"}, 64'(m_valid_o), 64'(0));
                check({nm, "_done_busy"},  64'(busy_o), 64'(0));
                check({nm, "_beats"},      64'(idx), 64'(N));
                if (pct == 100) check({nm, "_done_cycle"}, 64'(cyc), 64'(N + 1));
                finished = 1'b1;
            end else begin
                check({nm, "_busy"}, 64'(busy_o), 64'(1));
                if (m_valid_o) begin
                    if (idx < N) begin
                        check({nm, "_cls"},    64'(m_class_id_o), 64'(exp_c[idx]));
                        check({nm, "_frm"},    64'(m_frame_idx_o), 64'(exp_f[idx]));
                        check({nm, "_data"},   m_data_o, gen_word(exp_c[idx], exp_f[idx]));
                        check({nm, "_lastfr"}, 64'(m_last_frame_o), 64'(exp_f[idx] == NF - 1));
                        check({nm, "_last"},   64'(m_last_o), 64'(idx == N - 1));
                    end else begin
                        check({nm, "_extra_beat"}, 64'(1), 64'(0));
                    end
                end else if (prev_stall || (pct == 100 && cyc <= N)) begin
                    check({nm, "_valid"}, 64'(m_valid_o), 64'(1));
                end
            end
            if (!finished) begin
                if (low_beat >= 0 && idx == low_beat && m_valid_o && low_cnt < 5) begin
                    m_ready_i = 1'b0;
                    low_cnt++;
                end else begin
                    m_ready_i = (int'($urandom_range(99)) < pct);
                end
                if (start_noise) start_i = ($urandom_range(3) == 0);
                if (m_valid_o && idx == abort_beat) begin
                    abort_i = 1'b1;
                    m_ready_i = !abort_stall;
                    pend_abort = 1'b1;
                end
                if (m_valid_o && idx == rst_beat) begin
                    rst = 1'b1;
                    pend_rst = 1'b1;
                end
                prev_stall = m_valid_o && !m_ready_i;
                if (m_valid_o && m_ready_i && !pend_abort && !pend_rst) idx++;
            end
        end
        if (!finished) check({nm, "_timeout"}, 64'(0), 64'(1));
        start_i = 1'b0;
        abort_i = 1'b0;
    endtask

    initial begin
`ifdef CLASS_SEQ_FRAME_MAJOR_EN
        for (int f = 0; f < NF; f++)
            for (int c = 0; c < NC; c++) begin
                exp_c.push_back(c);
                exp_f.push_back(f);
            end
`else
        for (int c = 0; c < NC; c++)
            for (int f = 0; f < NF; f++) begin
                exp_c.push_back(c);
                exp_f.push_back(f);
            end
`endif
        rst = 1'b1;
        start_i = 1'b0;
        abort_i = 1'b0;
        m_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // abort_i in IDLE overrides start_i
        start_i = 1'b1;
        abort_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        abort_i = 1'b0;
        check("idle_abort_busy",  64'(busy_o), 64'(0));
        check("idle_abort_valid", 64'(m_valid_o), 64'(0));

        do_start("free");
        stream("free", 100, -1, -1, 1'b0, -1, 1'b0);
        do_start("b2b");
        stream("b2b", 100, -1, -1, 1'b0, -1, 1'b0);
        do_start("noise");
        stream("noise", 100, -1, -1, 1'b0, -1, 1'b1);

        do_start("bp");
        stream("bp", 50, 10, -1, 1'b0, -1, 1'b0);
        do_start("bp2");
        stream("bp2", 50, -1, -1, 1'b0, -1, 1'b1);

        do_start("abort_run");
        stream("abort_run", 100, -1, 7, 1'b0, -1, 1'b0);
        do_start("restart1");
        stream("restart1", 100, -1, -1, 1'b0, -1, 1'b0);
        do_start("abort_stall");
        stream("abort_stall", 50, -1, 7, 1'b1, -1, 1'b0);
        do_start("restart2");
        stream("restart2", 60, -1, -1, 1'b0, -1, 1'b0);

        do_start("rst_mid");
        stream("rst_mid", 60, -1, -1, 1'b0, 12, 1'b0);
        do_start("after_rst");
        stream("after_rst", 100, -1, -1, 1'b0, -1, 1'b0);

        @(negedge clk);
        check("final_done_low", 64'(done_o), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
